handshake_result_sink: RTL and testbench
========================================

HANDSHAKE_RESULT_SINK -- requirements
Module: handshake_result_sink

Interface
REQ-001 Parameter DATA_W, default 64: width of the result data channel.
REQ-002 Parameter EXP_RESULTS, default 2: number of out0 transfers that completes a run.
REQ-003 Parameter MAX_CYCLES, default 10000: number of RUN cycles before timeout.
REQ-004 Port clock  in  1: the single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1: reset, synchronous and active-high.
REQ-006 Port start  in  1: one-cycle pulse that begins a run.
REQ-007 Port out0_valid  in  1: the producer has result data available.
REQ-008 Port out0_ready  out  1: the sink accepts result data.
REQ-009 Port out0_data  in  DATA_W: result payload.
REQ-010 Port outCtrl_valid  in  1: the producer has a control token available.
REQ-011 Port outCtrl_ready  out  1: the sink accepts the control token.
REQ-012 Port res_cnt  out  16: number of accepted out0 transfers.
REQ-013 Port ctrl_cnt  out  16: number of accepted outCtrl transfers.
REQ-014 Port last_data  out  DATA_W: payload of the most recent out0 transfer.
REQ-015 Port checksum  out  DATA_W: XOR of all payloads accepted in the run.
REQ-016 Port done  out  1: high while the FSM is in DONE.
REQ-017 Port timeout_err  out  1: high while the FSM is in TIMEOUT.

Function
REQ-018 The FSM SHALL have four states: IDLE, RUN, DONE and TIMEOUT.
REQ-019 IDLE SHALL go to RUN on start; the same edge SHALL clear res_cnt, ctrl_cnt, last_data, checksum and the cycle counter.
REQ-020 DONE and TIMEOUT SHALL hold until start, which SHALL restart as in REQ-019; start SHALL be ignored in RUN.
REQ-021 out0_ready and outCtrl_ready SHALL be 0 outside RUN and equal the gate enable (REQ-030) in RUN; they SHALL be combinational only from state and gate, never from valid.
REQ-022 An out0 transfer SHALL occur on an edge where valid and ready are both 1; it SHALL increment res_cnt, load last_data, and XOR out0_data into checksum. Latency is one cycle to the outputs.
REQ-023 An outCtrl transfer SHALL increment ctrl_cnt, independent of out0; simultaneous transfers on both channels SHALL both be counted.
REQ-024 A transfer that brings res_cnt to EXP_RESULTS SHALL move RUN to DONE on that same edge; ready SHALL be 0 from the next cycle.
REQ-025 The cycle counter SHALL increment each RUN cycle; at MAX_CYCLES-1 with no completing transfer, the FSM SHALL go to TIMEOUT.
REQ-026 If the completing transfer and the timeout edge coincide, DONE SHALL win.
REQ-027 res_cnt and ctrl_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-028 Reset SHALL override start and take effect at the next edge, including mid-run.
REQ-029 Reset SHALL put the FSM in IDLE and drive every output to 0: both ready signals, both counters, last_data, checksum, done and timeout_err.

Configuration
REQ-030 With HS_SINK_THROTTLE_EN defined, the gate SHALL be bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset and on start) that advances every RUN cycle.
REQ-031 With HS_SINK_THROTTLE_EN undefined, the gate SHALL be constant 1 and no LFSR SHALL be instantiated.

Structure
REQ-032 Package handshake_sink_pkg SHALL hold the state enum, the counter width (16), the LFSR seed and the tap constants.
REQ-033 The LFSR SHALL be the sub-module handshake_ready_lfsr, instantiated only under HS_SINK_THROTTLE_EN.

Verification
REQ-034 Basic run: after reset, pulse start, then present data 0 and then 24 with valid held -> res_cnt=2, last_data=24, checksum=24; done rises on the edge of the second transfer; out0_ready=0 the next cycle.
REQ-035 Timeout: MAX_CYCLES=50, start, out0_valid never asserted -> timeout_err=1 after 50 RUN cycles; res_cnt=0.
REQ-036 Coincidence: MAX_CYCLES=10, second transfer on the 10th RUN cycle -> done=1 and timeout_err=0.
REQ-037 Reset mid-run: assert reset after 1 transfer -> all outputs 0 and FSM in IDLE next cycle; a following start and two transfers -> done.
REQ-038 Throttle (HS_SINK_THROTTLE_EN): valid held high, 8 payloads 1..8, EXP_RESULTS=8 -> ready follows the LFSR bit 0; transfers only when gate=1; checksum=8; no payload lost or duplicated.
REQ-039 Ctrl independence: 3 outCtrl tokens, 2 out0 transfers -> ctrl_cnt=3 if all arrive before DONE; completion depends on res_cnt only.

Source files
------------

// File: rtl/handshake_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module : handshake_sink_pkg
// Brief  : Shared types and constants for the handshake result sink: FSM
//          state encoding, counter width, ready-throttle LFSR seed and taps.
// Rev    : 1.0  initial release
// ============================================================================
package handshake_sink_pkg;

  // Sink run-control states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // Width of the transfer counters (res_cnt / ctrl_cnt)
  localparam int c_CNT_W = 16;

  // Throttle LFSR reset/restart value
  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bit
  // indices 0,2,3,5 of the register.
  localparam logic [15:0] c_LFSR_TAPS = 16'h002D;

  // One LFSR step: parity of the tapped bits shifts in at the top.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & c_LFSR_TAPS), s[15:1]};
  endfunction

endpackage : handshake_sink_pkg
`default_nettype wire

// File: rtl/handshake_ready_lfsr.sv
`default_nettype none
// ============================================================================
// Module : handshake_ready_lfsr
// Brief  : 16-bit Fibonacci LFSR whose bit 0 gates the sink ready signals.
//          Reloads the seed on reset or on i_seed, steps on i_advance.
// Rev    : 1.0  initial release
// ============================================================================
module handshake_ready_lfsr
  import handshake_sink_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_seed,
  input  logic i_advance,
  output logic o_gate
);

  logic [15:0] r_lfsr;

  // Seed on reset/run start, otherwise step once per enabled cycle
  always_ff @(posedge clk) begin
    if (rst || i_seed) begin
      r_lfsr <= c_LFSR_SEED;
    end else if (i_advance) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_gate = r_lfsr[0];

endmodule : handshake_ready_lfsr
`default_nettype wire

// File: rtl/handshake_result_sink.sv
`default_nettype none
// ============================================================================
// Module : handshake_result_sink
// Brief  : Result sink for a valid/ready producer. Counts out0 and outCtrl
//          transfers, tracks the last payload and an XOR checksum, and ends
//          a run in DONE after EXP_RESULTS results or TIMEOUT after
//          MAX_CYCLES run cycles.
// Config : HS_SINK_THROTTLE_EN - when defined, ready is gated by bit 0 of a
//          pseudo-random LFSR (handshake_ready_lfsr); otherwise always open.
// Rev    : 1.0  initial release
// ============================================================================
module handshake_result_sink
  import handshake_sink_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int EXP_RESULTS = 2,
  parameter int MAX_CYCLES  = 10000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                out0_valid,
  output logic                out0_ready,
  input  logic [DATA_W-1:0]   out0_data,
  input  logic                outCtrl_valid,
  output logic                outCtrl_ready,
  output logic [c_CNT_W-1:0]  res_cnt,
  output logic [c_CNT_W-1:0]  ctrl_cnt,
  output logic [DATA_W-1:0]   last_data,
  output logic [DATA_W-1:0]   checksum,
  output logic                done,
  output logic                timeout_err
);

  // Cycle counter only needs to reach MAX_CYCLES-1
  localparam int                 c_CYC_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(MAX_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_EXP      = c_CNT_W'(EXP_RESULTS);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CYC_W-1:0]   r_cyc;
  logic [c_CNT_W-1:0]   r_res_cnt;
  logic [c_CNT_W-1:0]   r_ctrl_cnt;
  logic [DATA_W-1:0]    r_last_data;
  logic [DATA_W-1:0]    r_checksum;

  logic                 w_gate;
  logic                 w_run;
  logic                 w_ready;
  logic                 w_xfer0;
  logic                 w_xferc;
  logic                 w_start_run;
  logic                 w_complete;
  logic [c_CNT_W-1:0]   w_res_inc;
  logic [c_CNT_W-1:0]   w_ctrl_inc;

`ifdef HS_SINK_THROTTLE_EN
  handshake_ready_lfsr u_ready_lfsr (
    .clk       (clock),
    .rst       (reset),
    .i_seed    (w_start_run),
    .i_advance (w_run),
    .o_gate    (w_gate)
  );
`else
  assign w_gate = 1'b1;
`endif

  // Ready depends only on state and gate so the producer never sees a
  // combinational path from its own valid back to ready.
  assign w_run      = (r_state == ST_RUN);
  assign w_ready    = w_run & w_gate;
  assign w_xfer0    = w_ready & out0_valid;
  assign w_xferc    = w_ready & outCtrl_valid;
  assign w_res_inc  = (r_res_cnt  == c_CNT_MAX) ? r_res_cnt  : r_res_cnt  + 16'd1;
  assign w_ctrl_inc = (r_ctrl_cnt == c_CNT_MAX) ? r_ctrl_cnt : r_ctrl_cnt + 16'd1;
  assign w_complete = w_xfer0 && (w_res_inc == c_EXP);

  // Next-state: start is honoured everywhere except RUN; completion beats timeout
  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_start_run = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_complete) begin
          w_state_nxt = ST_DONE;
        end else if (r_cyc == c_CYC_LAST) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Run datapath: cleared on run start, updated by accepted transfers
  always_ff @(posedge clock) begin
    if (reset || w_start_run) begin
      r_cyc       <= '0;
      r_res_cnt   <= '0;
      r_ctrl_cnt  <= '0;
      r_last_data <= '0;
      r_checksum  <= '0;
    end else if (w_run) begin
      r_cyc <= r_cyc + 1'b1;
      if (w_xfer0) begin
        r_res_cnt   <= w_res_inc;
        r_last_data <= out0_data;
        r_checksum  <= r_checksum ^ out0_data;
      end
      if (w_xferc) begin
        r_ctrl_cnt <= w_ctrl_inc;
      end
    end
  end

  assign out0_ready    = w_ready;
  assign outCtrl_ready = w_ready;
  assign res_cnt       = r_res_cnt;
  assign ctrl_cnt      = r_ctrl_cnt;
  assign last_data     = r_last_data;
  assign checksum      = r_checksum;
  assign done          = (r_state == ST_DONE);
  assign timeout_err   = (r_state == ST_TIMEOUT);

endmodule : handshake_result_sink
`default_nettype wire

// File: tb/tb_handshake_result_sink.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_handshake_result_sink
// Brief  : Directed self-checking bench for handshake_result_sink.
//          Instance A: MAX_CYCLES=50, EXP_RESULTS=2. Instance B: MAX_CYCLES=10.
//          Instance C (HS_SINK_THROTTLE_EN only): EXP_RESULTS=8.
// Rev    : 1.0  initial release
// ============================================================================
module tb_handshake_result_sink;

  localparam int DW = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic          a_reset, a_start, a_v0, a_vc, a_r0, a_rc, a_done, a_to;
  logic [DW-1:0] a_d0, a_last, a_sum;
  logic [15:0]   a_res, a_ctrl;
  // Instance B signals
  logic          b_reset, b_start, b_v0, b_vc, b_r0, b_rc, b_done, b_to;
  logic [DW-1:0] b_d0, b_last, b_sum;
  logic [15:0]   b_res, b_ctrl;

  handshake_result_sink #(.DATA_W(DW), .EXP_RESULTS(2), .MAX_CYCLES(50)) u_dut_a (
    .clock(clock), .reset(a_reset), .start(a_start),
    .out0_valid(a_v0), .out0_ready(a_r0), .out0_data(a_d0),
    .outCtrl_valid(a_vc), .outCtrl_ready(a_rc),
    .res_cnt(a_res), .ctrl_cnt(a_ctrl), .last_data(a_last), .checksum(a_sum),
    .done(a_done), .timeout_err(a_to)
  );

  handshake_result_sink #(.DATA_W(DW), .EXP_RESULTS(2), .MAX_CYCLES(10)) u_dut_b (
    .clock(clock), .reset(b_reset), .start(b_start),
    .out0_valid(b_v0), .out0_ready(b_r0), .out0_data(b_d0),
    .outCtrl_valid(b_vc), .outCtrl_ready(b_rc),
    .res_cnt(b_res), .ctrl_cnt(b_ctrl), .last_data(b_last), .checksum(b_sum),
    .done(b_done), .timeout_err(b_to)
  );

`ifdef HS_SINK_THROTTLE_EN
  logic          c_reset, c_start, c_v0, c_vc, c_r0, c_rc, c_done, c_to;
  logic [DW-1:0] c_d0, c_last, c_sum;
  logic [15:0]   c_res, c_ctrl;

  handshake_result_sink #(.DATA_W(DW), .EXP_RESULTS(8), .MAX_CYCLES(1000)) u_dut_c (
    .clock(clock), .reset(c_reset), .start(c_start),
    .out0_valid(c_v0), .out0_ready(c_r0), .out0_data(c_d0),
    .outCtrl_valid(c_vc), .outCtrl_ready(c_rc),
    .res_cnt(c_res), .ctrl_cnt(c_ctrl), .last_data(c_last), .checksum(c_sum),
    .done(c_done), .timeout_err(c_to)
  );
`endif

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one payload on instance A and hold valid until it is accepted
  task automatic a_send(input logic [DW-1:0] d);
    bit sent = 0;
    a_v0 = 1'b1;
    a_d0 = d;
    for (int n = 0; n < 64 && !sent; n++) begin
      if (a_r0) sent = 1;
      step();
    end
    a_v0 = 1'b0;
    if (!sent) begin
      checks++;
      errors++;
      $display("FAIL a_send_wait: payload %0d not accepted, ready=%b", d, a_r0);
    end
  endtask

  task automatic start_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    step(); step();
    checks++; if (a_res !== 16'd0 || a_ctrl !== 16'd0) begin errors++;
      $display("FAIL reset_counters: res=%0d ctrl=%0d expected 0/0", a_res, a_ctrl); end
    checks++; if (a_last !== '0 || a_sum !== '0) begin errors++;
      $display("FAIL reset_data: last=%0h sum=%0h expected 0", a_last, a_sum); end
    checks++; if ({a_r0, a_rc, a_done, a_to} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: r0 rc done to=%b expected 0000", {a_r0, a_rc, a_done, a_to}); end
    a_reset = 1'b0; b_reset = 1'b0;
    step();
    checks++; if ({a_r0, a_done, a_to} !== 3'b000) begin errors++;
      $display("FAIL idle_hold: r0 done to=%b expected 000", {a_r0, a_done, a_to}); end
  endtask

  task automatic test_basic();
    start_a();
    checks++; if (a_r0 !== 1'b1 || a_rc !== 1'b1) begin errors++;
      $display("FAIL basic_ready_run: r0=%b rc=%b expected 1/1", a_r0, a_rc); end
    a_send(64'd0);
    checks++; if (a_res !== 16'd1 || a_done !== 1'b0) begin errors++;
      $display("FAIL basic_first: res=%0d done=%b expected 1/0", a_res, a_done); end
    a_send(64'd24);
    checks++; if (a_done !== 1'b1 || a_res !== 16'd2) begin errors++;
      $display("FAIL basic_done: done=%b res=%0d expected 1/2", a_done, a_res); end
    checks++; if (a_last !== 64'd24 || a_sum !== 64'd24) begin errors++;
      $display("FAIL basic_data: last=%0d sum=%0d expected 24/24", a_last, a_sum); end
    checks++; if (a_r0 !== 1'b0) begin errors++;
      $display("FAIL basic_ready_off: r0=%b expected 0", a_r0); end
    step();
    checks++; if (a_done !== 1'b1 || a_res !== 16'd2) begin errors++;
      $display("FAIL basic_done_hold: done=%b res=%0d expected 1/2", a_done, a_res); end
  endtask

  task automatic test_timeout();
    start_a();
    checks++; if (a_res !== 16'd0 || a_last !== '0 || a_sum !== '0 || a_done !== 1'b0) begin errors++;
      $display("FAIL restart_clear: res=%0d last=%0d sum=%0d done=%b expected 0", a_res, a_last, a_sum, a_done); end
    for (int i = 0; i < 49; i++) step();
    checks++; if (a_to !== 1'b0 || a_r0 !== 1'b1) begin errors++;
      $display("FAIL timeout_early: to=%b r0=%b after 49 cycles expected 0/1", a_to, a_r0); end
    step();
    checks++; if (a_to !== 1'b1 || a_done !== 1'b0 || a_res !== 16'd0 || a_r0 !== 1'b0) begin errors++;
      $display("FAIL timeout_fire: to=%b done=%b res=%0d r0=%b expected 1/0/0/0", a_to, a_done, a_res, a_r0); end
  endtask

  task automatic test_coincidence();
    b_start = 1'b1; step(); b_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    b_v0 = 1'b1; b_d0 = 64'd5; step(); b_v0 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (b_to !== 1'b0 || b_done !== 1'b0 || b_res !== 16'd1) begin errors++;
      $display("FAIL coinc_pre: to=%b done=%b res=%0d expected 0/0/1", b_to, b_done, b_res); end
    b_v0 = 1'b1; b_d0 = 64'd3; step(); b_v0 = 1'b0;
    checks++; if (b_done !== 1'b1 || b_to !== 1'b0) begin errors++;
      $display("FAIL coinc_done_wins: done=%b to=%b expected 1/0", b_done, b_to); end
    checks++; if (b_res !== 16'd2 || b_sum !== 64'd6) begin errors++;
      $display("FAIL coinc_data: res=%0d sum=%0d expected 2/6", b_res, b_sum); end
  endtask

  task automatic test_reset_midrun();
    start_a();
    a_send(64'd7);
    checks++; if (a_res !== 16'd1 || a_last !== 64'd7) begin errors++;
      $display("FAIL mid_pre: res=%0d last=%0d expected 1/7", a_res, a_last); end
    a_reset = 1'b1; a_start = 1'b1;
    step();
    checks++; if (a_res !== 16'd0 || a_last !== '0 || a_sum !== '0 || a_ctrl !== 16'd0) begin errors++;
      $display("FAIL mid_reset_data: res=%0d last=%0d sum=%0d ctrl=%0d expected 0", a_res, a_last, a_sum, a_ctrl); end
    checks++; if ({a_r0, a_rc, a_done, a_to} !== 4'b0000) begin errors++;
      $display("FAIL mid_reset_idle: r0 rc done to=%b expected 0000", {a_r0, a_rc, a_done, a_to}); end
    a_reset = 1'b0; a_start = 1'b0;
    step();
    checks++; if (a_r0 !== 1'b0) begin errors++;
      $display("FAIL mid_idle_stay: r0=%b expected 0", a_r0); end
    start_a();
    a_send(64'd1);
    a_send(64'd2);
    checks++; if (a_done !== 1'b1 || a_sum !== 64'd3 || a_last !== 64'd2) begin errors++;
      $display("FAIL mid_rerun: done=%b sum=%0d last=%0d expected 1/3/2", a_done, a_sum, a_last); end
  endtask

  task automatic test_ctrl();
    start_a();
    a_vc = 1'b1;
    step(); step();
    a_v0 = 1'b1; a_d0 = 64'd9;
    step();
    a_v0 = 1'b0; a_vc = 1'b0;
    checks++; if (a_ctrl !== 16'd3 || a_res !== 16'd1) begin errors++;
      $display("FAIL ctrl_simul: ctrl=%0d res=%0d expected 3/1", a_ctrl, a_res); end
    checks++; if (a_done !== 1'b0) begin errors++;
      $display("FAIL ctrl_no_done: done=%b expected 0", a_done); end
    a_send(64'd10);
    checks++; if (a_done !== 1'b1 || a_res !== 16'd2 || a_sum !== 64'd3) begin errors++;
      $display("FAIL ctrl_done: done=%b res=%0d sum=%0d expected 1/2/3", a_done, a_res, a_sum); end
    a_vc = 1'b1;
    step();
    a_vc = 1'b0;
    checks++; if (a_ctrl !== 16'd3 || a_rc !== 1'b0) begin errors++;
      $display("FAIL ctrl_after_done: ctrl=%0d rc=%b expected 3/0", a_ctrl, a_rc); end
  endtask

`ifdef HS_SINK_THROTTLE_EN
  task automatic test_throttle();
    logic [15:0] m;
    logic        fb;
    int          idx;
    int          bad;
    c_reset = 1'b1; step(); c_reset = 1'b0;
    c_start = 1'b1; step(); c_start = 1'b0;
    m = 16'hACE1;
    idx = 0;
    bad = 0;
    c_v0 = 1'b1;
    for (int n = 0; n < 300 && idx < 8; n++) begin
      c_d0 = 64'(idx + 1);
      if (c_r0 !== m[0]) bad++;
      if (c_r0 === 1'b1) idx++;
      step();
      fb = m[0] ^ m[2] ^ m[3] ^ m[5];
      m  = {fb, m[15:1]};
    end
    c_v0 = 1'b0;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL throttle_gate: %0d cycles where ready differed from model LFSR", bad); end
    checks++; if (c_done !== 1'b1 || c_res !== 16'd8) begin errors++;
      $display("FAIL throttle_done: done=%b res=%0d expected 1/8", c_done, c_res); end
    checks++; if (c_sum !== 64'd8 || c_last !== 64'd8) begin errors++;
      $display("FAIL throttle_data: sum=%0d last=%0d expected 8/8", c_sum, c_last); end
  endtask
`endif

  initial begin
    a_reset = 1'b1; a_start = 1'b0; a_v0 = 1'b0; a_vc = 1'b0; a_d0 = '0;
    b_reset = 1'b1; b_start = 1'b0; b_v0 = 1'b0; b_vc = 1'b0; b_d0 = '0;
`ifdef HS_SINK_THROTTLE_EN
    c_reset = 1'b1; c_start = 1'b0; c_v0 = 1'b0; c_vc = 1'b0; c_d0 = '0;
`endif
    #1;
    test_reset();
    test_basic();
    test_timeout();
    test_reset_midrun();
`ifdef HS_SINK_THROTTLE_EN
    test_throttle();
`else
    test_coincidence();
    test_ctrl();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule : tb_handshake_result_sink
`default_nettype wire
